// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the sync_fifo_prog slice.
//   DEF_DATA_WIDTH / DEF_DEPTH : default word width and number of entries
//   occ_width()                : width of an occupancy counter for a given depth
//   fifo_status_t              : bundle of the FIFO status flags
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;

  // Occupancy must represent 0..DEPTH inclusive, so it needs one bit more
  // than the pointer.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: producer/consumer handshake and status bundle of the FIFO.
//   master : the user side (drives requests, data, thresholds, err_clr)
//   slave  : the FIFO side (drives read data, acks, errors, count, flags)
// Clock and reset are not part of the bundle.
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
);
  localparam int AW = $clog2(DEPTH);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  ovf_sticky;
  logic                  udf_sticky;
  logic                  err_clr;
  logic [AW:0]           af_thresh;
  logic [AW:0]           ae_thresh;
  logic [AW:0]           count;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;

  modport master (
    output wr_en, data_in, rd_en, err_clr, af_thresh, ae_thresh,
    input  data_out, rd_valid, wr_ack, overflow, underflow, ovf_sticky,
           udf_sticky, count, full, empty, almostfull, almostempty
  );

  modport slave (
    input  wr_en, data_in, rd_en, err_clr, af_thresh, ae_thresh,
    output data_out, rd_valid, wr_ack, overflow, underflow, ovf_sticky,
           udf_sticky, count, full, empty, almostfull, almostempty
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage, one synchronous write port and one
// asynchronous read port. Contents are not reset.
//   clk     : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: parametrised single-clock FIFO with programmable
// almost-full/almost-empty thresholds, occupancy count, one-cycle
// ack/overflow/underflow pulses and sticky error flags.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sync_fifo_prog_if.slave (requests, data, thresholds, status)
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (data_out shows the head word combinationally, rd_valid = !empty).
// Without it, data_out/rd_valid are registered one cycle after a pop.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input logic            clk,
  input logic            rst_n,
  sync_fifo_prog_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_wr_ack;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_ovf_sticky;
  logic                  r_udf_sticky;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [DATA_WIDTH-1:0] w_mem_rd;
  fifo_status_t          w_status;

  // A write into a full FIFO still goes through when a read frees a slot
  // on the same edge.
  assign w_rd_acc = bus.rd_en && (r_count != '0);
  assign w_wr_acc = bus.wr_en && ((r_count < FULL_CNT) || w_rd_acc);

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_mem_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_wr_ack     <= 1'b0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_udf_sticky <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (!w_wr_acc && w_rd_acc) r_count <= r_count - 1'b1;
      r_wr_ack <= w_wr_acc;
      r_ovf    <= bus.wr_en && !w_wr_acc;
      r_udf    <= bus.rd_en && !w_rd_acc;
      // A new error on the clearing edge must not be lost: set beats clear.
      if (bus.wr_en && !w_wr_acc) r_ovf_sticky <= 1'b1;
      else if (bus.err_clr)       r_ovf_sticky <= 1'b0;
      if (bus.rd_en && !w_rd_acc) r_udf_sticky <= 1'b1;
      else if (bus.err_clr)       r_udf_sticky <= 1'b0;
    end
  end

  always_comb begin
    w_status             = '0;
    w_status.full        = (r_count == FULL_CNT);
    w_status.empty       = (r_count == '0);
    w_status.almostfull  = (r_count >= bus.af_thresh);
    w_status.almostempty = (r_count <= bus.ae_thresh);
    w_status.overflow    = r_ovf;
    w_status.underflow   = r_udf;
  end

  assign bus.full        = w_status.full;
  assign bus.empty       = w_status.empty;
  assign bus.almostfull  = w_status.almostfull;
  assign bus.almostempty = w_status.almostempty;
  assign bus.overflow    = w_status.overflow;
  assign bus.underflow   = w_status.underflow;
  assign bus.wr_ack      = r_wr_ack;
  assign bus.ovf_sticky  = r_ovf_sticky;
  assign bus.udf_sticky  = r_udf_sticky;
  assign bus.count       = r_count;

`ifdef FIFO_FWFT_EN
  // Head word is always on display; rd_en only retires it.
  assign bus.data_out = w_mem_rd;
  assign bus.rd_valid = !w_status.empty;
`else
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_dout <= w_mem_rd;
    end
  end

  assign bus.data_out = r_dout;
  assign bus.rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed bench for sync_fifo_prog (DATA_WIDTH=16,
// DEPTH=8). Covers the standard build and, when FIFO_FWFT_EN is defined,
// the first-word-fall-through build.
module tb_sync_fifo_prog;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  sync_fifo_prog_if #(.DATA_WIDTH(16), .DEPTH(8)) bus ();

  sync_fifo_prog #(.DATA_WIDTH(16), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.wr_en     = 1'b0;
    bus.rd_en     = 1'b0;
    bus.data_in   = '0;
    bus.err_clr   = 1'b0;
    bus.af_thresh = 4'd6;
    bus.ae_thresh = 4'd1;
    tick();
    tick();

    // Reset state
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ae", bus.almostempty, 1);
    chk("rst_af", bus.almostfull, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_wr_ack", bus.wr_ack, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);
`ifndef FIFO_FWFT_EN
    chk("rst_dout", bus.data_out, 0);
`endif
    rst_n = 1'b1;
    tick();

`ifdef FIFO_FWFT_EN
    // Fall-through: written word appears without rd_en
    bus.wr_en = 1'b1; bus.data_in = 16'h1234;
    tick();
    bus.wr_en = 1'b0;
    chk("fwft_dout", bus.data_out, 16'h1234);
    chk("fwft_valid", bus.rd_valid, 1);
    tick();
    chk("fwft_hold", bus.data_out, 16'h1234);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("fwft_empty", bus.empty, 1);
    chk("fwft_valid0", bus.rd_valid, 0);
`endif

    // Fill with 1..8
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 16'(i);
      tick();
      chk($sformatf("fill_count%0d", i), bus.count, i);
      chk($sformatf("fill_ack%0d", i), bus.wr_ack, 1);
      chk($sformatf("fill_af%0d", i), bus.almostfull, (i >= 6) ? 1 : 0);
      chk($sformatf("fill_ae%0d", i), bus.almostempty, (i <= 1) ? 1 : 0);
      chk($sformatf("fill_full%0d", i), bus.full, (i == 8) ? 1 : 0);
    end
    bus.wr_en = 1'b0;
    tick();
    chk("full_ack_pulse", bus.wr_ack, 0);

    // Threshold beyond DEPTH: almostfull never asserts
    bus.af_thresh = 4'd9;
    #1;
    chk("af_thresh9", bus.almostfull, 0);
    bus.af_thresh = 4'd6;
    #1;
    chk("af_thresh6", bus.almostfull, 1);

    // Overflow on full
    bus.wr_en = 1'b1; bus.data_in = 16'hDEAD;
    tick();
    bus.wr_en = 1'b0;
    chk("ovf", bus.overflow, 1);
    chk("ovf_ack", bus.wr_ack, 0);
    chk("ovf_sticky", bus.ovf_sticky, 1);
    chk("ovf_count", bus.count, 8);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("ovf_clr", bus.ovf_sticky, 0);
    chk("ovf_pulse", bus.overflow, 0);

    // Full with simultaneous write and read
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 16'h0009;
`ifdef FIFO_FWFT_EN
    #1;
    chk("fullrw_head", bus.data_out, 16'h0001);
`endif
    tick();
    bus.wr_en = 1'b0;
    chk("fullrw_ack", bus.wr_ack, 1);
    chk("fullrw_ovf", bus.overflow, 0);
    chk("fullrw_count", bus.count, 8);
`ifndef FIFO_FWFT_EN
    chk("fullrw_dout", bus.data_out, 16'h0001);
    chk("fullrw_valid", bus.rd_valid, 1);
`endif

    // Drain 2..9 (9 sits at wrapped slot 0)
    for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk($sformatf("drain_dout%0d", i), bus.data_out, 16'(i + 2));
`endif
      tick();
`ifndef FIFO_FWFT_EN
      chk($sformatf("drain_dout%0d", i), bus.data_out, 16'(i + 2));
`endif
      chk($sformatf("drain_count%0d", i), bus.count, 7 - i);
    end
    bus.rd_en = 1'b0;
    chk("drain_empty", bus.empty, 1);

    // Empty with simultaneous write and read
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.data_in = 16'h00AA;
    tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("emptyrw_udf", bus.underflow, 1);
    chk("emptyrw_udfs", bus.udf_sticky, 1);
    chk("emptyrw_count", bus.count, 1);
    chk("emptyrw_ack", bus.wr_ack, 1);
`ifdef FIFO_FWFT_EN
    chk("emptyrw_valid", bus.rd_valid, 1);
    chk("emptyrw_head", bus.data_out, 16'h00AA);
`else
    chk("emptyrw_valid", bus.rd_valid, 0);
`endif
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
    chk("aa_dout", bus.data_out, 16'h00AA);
`endif
    chk("aa_count", bus.count, 0);
    chk("aa_udf_pulse", bus.underflow, 0);
    chk("aa_udfs_held", bus.udf_sticky, 1);

    // Reset mid-burst
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.data_in = 16'(16'h0030 + i);
      tick();
    end
    chk("burst_count", bus.count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_count", bus.count, 0);
    chk("mrst_empty", bus.empty, 1);
    chk("mrst_ack", bus.wr_ack, 0);
    chk("mrst_udfs", bus.udf_sticky, 0);
    chk("mrst_valid", bus.rd_valid, 0);
`ifndef FIFO_FWFT_EN
    chk("mrst_dout", bus.data_out, 0);
`endif
    bus.wr_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus.wr_en = 1'b1; bus.data_in = 16'h0055;
    tick();
    bus.wr_en = 1'b0;
    chk("post_count", bus.count, 1);
`ifdef FIFO_FWFT_EN
    chk("post_dout", bus.data_out, 16'h0055);
`endif
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
`ifndef FIFO_FWFT_EN
    chk("post_dout", bus.data_out, 16'h0055);
    chk("post_valid", bus.rd_valid, 1);
`endif
    chk("post_empty", bus.empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
